// File: rtl/aclk_time_counter.sv
// aclk_time_counter: real-time HH:MM BCD counter (24-hour) for the alarm clock.
// A seconds prescaler counts one_second pulses; every SEC_PER_MIN pulses the
// four BCD digits advance by one minute. A parallel load from the key register
// overrides any tick in the same cycle.
//
// Optional build macro ACLK_LOAD_CHECK_EN: when defined, loads of times that
// are not valid 24-hour HH:MM values are rejected and load_err pulses.
// When undefined, every load is accepted and load_err is tied to 0.
module aclk_time_counter #(
  parameter int SEC_PER_MIN = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       minute_tick,
  output logic       day_wrap,
  output logic       load_err
);

  // Four BCD digits of the time of day, most significant first.
  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  // Last prescaler value before the minute rolls over.
  localparam logic [7:0] SEC_LAST = 8'(SEC_PER_MIN - 1);

  bcd_time_t  time_q, time_d;
  bcd_time_t  new_time;
  logic [7:0] sec_cnt_q, sec_cnt_d;
  logic       tick_q, tick_d;
  logic       wrap_q, wrap_d;
  logic       load_ok;

  assign new_time = '{ms_hr:  new_current_time_ms_hr,
                      ls_hr:  new_current_time_ls_hr,
                      ms_min: new_current_time_ms_min,
                      ls_min: new_current_time_ls_min};

`ifdef ACLK_LOAD_CHECK_EN
  logic err_q, err_d;

  // Accept only a well-formed 24-hour time: 00:00 .. 23:59.
  always_comb begin
    load_ok = (new_time.ls_min <= 4'd9) &&
              (new_time.ms_min <= 4'd5) &&
              (new_time.ls_hr  <= 4'd9) &&
              (new_time.ms_hr  <= 4'd2) &&
              !((new_time.ms_hr == 4'd2) && (new_time.ls_hr > 4'd3));
  end
`else
  // Unchecked loads: out-of-range digits self-correct at the next rollover.
  assign load_ok = 1'b1;
`endif

  // Next-state logic: load has priority over the seconds prescaler.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (otherwise synthesis infers a latch).
    time_d    = time_q;
    sec_cnt_d = sec_cnt_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
`ifdef ACLK_LOAD_CHECK_EN
    err_d     = 1'b0;
`endif

    if (load_new_c) begin
      // Any one_second in this cycle is discarded, accepted load or not.
      if (load_ok) begin
        time_d    = new_time;
        sec_cnt_d = 8'd0;
      end
`ifdef ACLK_LOAD_CHECK_EN
      else begin
        err_d = 1'b1;
      end
`endif
    end else if (one_second) begin
      if (sec_cnt_q == SEC_LAST) begin
        sec_cnt_d = 8'd0;
        tick_d    = 1'b1;
        // Minute cascade. The >= tests let out-of-range digits fall back to 0
        // at the next carry instead of counting through illegal codes forever.
        if (time_q.ls_min >= 4'd9) begin
          time_d.ls_min = 4'd0;
          if (time_q.ms_min >= 4'd5) begin
            time_d.ms_min = 4'd0;
            if ((time_q.ms_hr >= 4'd2) && (time_q.ls_hr >= 4'd3)) begin
              time_d.ms_hr = 4'd0;
              time_d.ls_hr = 4'd0;
              wrap_d       = 1'b1;
            end else if (time_q.ls_hr >= 4'd9) begin
              time_d.ls_hr = 4'd0;
              time_d.ms_hr = time_q.ms_hr + 4'd1;
            end else begin
              time_d.ls_hr = time_q.ls_hr + 4'd1;
            end
          end else begin
            time_d.ms_min = time_q.ms_min + 4'd1;
          end
        end else begin
          time_d.ls_min = time_q.ls_min + 4'd1;
        end
      end else begin
        sec_cnt_d = sec_cnt_q + 8'd1;
      end
    end
  end

  // State and pulse registers with asynchronous clear to 00:00.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      time_q    <= '0;
      sec_cnt_q <= 8'd0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      time_q    <= time_d;
      sec_cnt_q <= sec_cnt_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef ACLK_LOAD_CHECK_EN
  // Rejected-load pulse register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign current_time_ms_hr  = time_q.ms_hr;
  assign current_time_ls_hr  = time_q.ls_hr;
  assign current_time_ms_min = time_q.ms_min;
  assign current_time_ls_min = time_q.ls_min;
  assign minute_tick         = tick_q;
  assign day_wrap            = wrap_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Testbench for aclk_time_counter. The reference model keeps the time as
// minutes-of-day for legal values and applies the digit-wise fallback rules
// only for out-of-range digits left behind by an unchecked load.
module tb_aclk_time_counter;

  localparam int SPM = 4;

  logic       clk;
  logic       rst;
  logic       one_second;
  logic       load_new_c;
  logic [3:0] n_mh, n_lh, n_mm, n_lm;
  logic [3:0] c_mh, c_lh, c_mm, c_lm;
  logic       minute_tick, day_wrap, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: expected values after the most recent edge.
  int e_mh, e_lh, e_mm, e_lm;
  int e_sec;
  logic e_tick, e_wrap, e_err;

  aclk_time_counter #(.SEC_PER_MIN(SPM)) dut (
    .clock                   (clk),
    .reset                   (rst),
    .one_second              (one_second),
    .load_new_c              (load_new_c),
    .new_current_time_ms_hr  (n_mh),
    .new_current_time_ls_hr  (n_lh),
    .new_current_time_ms_min (n_mm),
    .new_current_time_ls_min (n_lm),
    .current_time_ms_hr      (c_mh),
    .current_time_ls_hr      (c_lh),
    .current_time_ms_min     (c_mm),
    .current_time_ls_min     (c_lm),
    .minute_tick             (minute_tick),
    .day_wrap                (day_wrap),
    .load_err                (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] obs_vec();
    return {c_mh, c_lh, c_mm, c_lm, minute_tick, day_wrap, load_err};
  endfunction

  function automatic logic [18:0] exp_vec();
    return {4'(e_mh), 4'(e_lh), 4'(e_mm), 4'(e_lm), e_tick, e_wrap, e_err};
  endfunction

  function automatic bit is_legal(int mh, int lh, int mm, int lm);
    return (mh <= 2) && (lh <= 9) && (mm <= 5) && (lm <= 9) && !(mh == 2 && lh > 3);
  endfunction

  function automatic void model_reset();
    e_mh = 0; e_lh = 0; e_mm = 0; e_lm = 0; e_sec = 0;
    e_tick = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
  endfunction

  // One minute forward.
  function automatic void model_advance();
    int m;
    if (is_legal(e_mh, e_lh, e_mm, e_lm)) begin
      m      = (e_mh * 10 + e_lh) * 60 + e_mm * 10 + e_lm + 1;
      e_wrap = (m == 24 * 60);
      m      = m % (24 * 60);
      e_mh   = m / 600;
      e_lh   = (m / 60) % 10;
      e_mm   = (m % 60) / 10;
      e_lm   = m % 10;
    end else begin
      // Out-of-range digits: any digit at or past its top value resets to 0.
      e_wrap = 1'b0;
      if (e_lm < 9) e_lm = e_lm + 1;
      else begin
        e_lm = 0;
        if (e_mm < 5) e_mm = e_mm + 1;
        else begin
          e_mm = 0;
          if (e_mh >= 2 && e_lh >= 3) begin
            e_mh = 0; e_lh = 0; e_wrap = 1'b1;
          end else if (e_lh >= 9) begin
            e_lh = 0; e_mh = (e_mh + 1) & 15;
          end else e_lh = e_lh + 1;
        end
      end
    end
  endfunction

  function automatic void model_step(logic ld, logic os, logic [15:0] nt);
    bit accept;
    e_tick = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
`ifdef ACLK_LOAD_CHECK_EN
    accept = is_legal(int'(nt[15:12]), int'(nt[11:8]), int'(nt[7:4]), int'(nt[3:0]));
`else
    accept = 1'b1;
`endif
    if (ld) begin
      if (accept) begin
        e_mh = int'(nt[15:12]); e_lh = int'(nt[11:8]);
        e_mm = int'(nt[7:4]);   e_lm = int'(nt[3:0]);
        e_sec = 0;
      end else e_err = 1'b1;
    end else if (os) begin
      if (e_sec == SPM - 1) begin
        e_sec  = 0;
        e_tick = 1'b1;
        model_advance();
      end else e_sec = e_sec + 1;
    end
  endfunction

  // Apply inputs for one clock, predict the result, sample #1 after the edge.
  task automatic drive(input logic ld, input logic os, input logic [15:0] nt);
    load_new_c = ld;
    one_second = os;
    {n_mh, n_lh, n_mm, n_lm} = nt;
    model_step(ld, os, nt);
    @(posedge clk);
    #1;
    load_new_c = 1'b0;
    one_second = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (obs_vec() !== exp_vec() || obs_vec() !== 19'd0)
      $display("FAIL reset_state: got %h expected %h", obs_vec(), 19'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h1234);
    drive(1'b0, 1'b1, 16'h0);
    drive(1'b0, 1'b1, 16'h0);
    n_checks++;
    if (obs_vec() !== exp_vec() || {c_mh, c_lh, c_mm, c_lm} !== 16'h1234) begin
      n_fail++;
      $display("FAIL load_1234: got %h expected %h", obs_vec(), exp_vec());
    end
    // Assert mid-cycle; the clear must show before any further edge.
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== 19'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs_vec(), 19'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // First minute after reset release needs a full SPM pulses.
  task automatic test_first_minute();
    for (int i = 1; i <= SPM; i++) begin
      drive(1'b0, 1'b1, 16'h0);
      n_checks++;
      if (obs_vec() !== exp_vec() || minute_tick !== (i == SPM)) begin
        n_fail++;
        $display("FAIL first_minute pulse %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    drive(1'b0, 1'b0, 16'h0);
    n_checks++;
    if (obs_vec() !== exp_vec() || {c_mh, c_lh, c_mm, c_lm} !== 16'h0001 || minute_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL first_minute_result: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_minute_rollover();
    drive(1'b1, 1'b0, 16'h0009);
    for (int i = 1; i <= SPM; i++) begin
      drive(1'b0, 1'b1, 16'h0);
      n_checks++;
      if (obs_vec() !== exp_vec() ||
          {c_mh, c_lh, c_mm, c_lm} !== ((i == SPM) ? 16'h0010 : 16'h0009)) begin
        n_fail++;
        $display("FAIL rollover_0009 pulse %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    drive(1'b0, 1'b0, 16'h0);
    n_checks++;
    if (minute_tick !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL tick_width: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_day_wrap();
    logic [15:0] start_t [2] = '{16'h2359, 16'h0959};
    logic [15:0] end_t   [2] = '{16'h0000, 16'h1000};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, start_t[k]);
      for (int i = 0; i < SPM; i++) drive(1'b0, 1'b1, 16'h0);
      n_checks++;
      if (obs_vec() !== exp_vec() ||
          obs_vec() !== {end_t[k], 1'b1, (k == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL day_wrap from %h: got %h expected %h", start_t[k], obs_vec(), {end_t[k], 1'b1, (k == 0), 1'b0});
      end
    end
  endtask

  // Load coincident with a due rollover: load wins, prescaler restarts.
  task automatic test_load_priority();
    drive(1'b1, 1'b0, 16'h0100);
    for (int i = 0; i < SPM - 1; i++) drive(1'b0, 1'b1, 16'h0);
    drive(1'b1, 1'b1, 16'h0730);
    n_checks++;
    if (obs_vec() !== exp_vec() || obs_vec() !== {16'h0730, 3'b000}) begin
      n_fail++;
      $display("FAIL load_priority: got %h expected %h", obs_vec(), {16'h0730, 3'b000});
    end
    for (int i = 1; i <= SPM; i++) begin
      drive(1'b0, 1'b1, 16'h0);
      n_checks++;
      if (obs_vec() !== exp_vec() ||
          {c_mh, c_lh, c_mm, c_lm} !== ((i == SPM) ? 16'h0731 : 16'h0730)) begin
        n_fail++;
        $display("FAIL after_load pulse %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef ACLK_LOAD_CHECK_EN
  task automatic test_load_check();
    logic [15:0] ld_t [3] = '{16'h2400, 16'h1960, 16'h2359};
    drive(1'b1, 1'b0, 16'h1200);
    drive(1'b0, 1'b1, 16'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, ld_t[k]);
      n_checks++;
      if (obs_vec() !== exp_vec() ||
          obs_vec() !== ((k < 2) ? {16'h1200, 3'b001} : {16'h2359, 3'b000})) begin
        n_fail++;
        $display("FAIL load_check %h: got %h expected %h", ld_t[k], obs_vec(), exp_vec());
      end
      drive(1'b0, 1'b0, 16'h0);
      n_checks++;
      if (load_err !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL load_err_width %h: got %h expected %h", ld_t[k], obs_vec(), exp_vec());
      end
    end
  endtask
`else
  task automatic test_unchecked_load();
    drive(1'b1, 1'b0, 16'h000F);
    n_checks++;
    if (obs_vec() !== exp_vec() || obs_vec() !== {16'h000F, 3'b000}) begin
      n_fail++;
      $display("FAIL load_000F: got %h expected %h", obs_vec(), {16'h000F, 3'b000});
    end
    for (int i = 0; i < SPM; i++) drive(1'b0, 1'b1, 16'h0);
    n_checks++;
    if (obs_vec() !== exp_vec() || obs_vec() !== {16'h0010, 3'b100}) begin
      n_fail++;
      $display("FAIL selfcorrect_000F: got %h expected %h", obs_vec(), {16'h0010, 3'b100});
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] nt;
    int m;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        m  = $urandom_range(0, 24 * 60 - 1);
        nt = {4'(m / 600), 4'((m / 60) % 10), 4'((m % 60) / 10), 4'(m % 10)};
      end else nt = 16'($urandom);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, nt);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    one_second = 1'b0;
    load_new_c = 1'b0;
    {n_mh, n_lh, n_mm, n_lm} = 16'h0;
    test_reset();
    test_first_minute();
    test_minute_rollover();
    test_day_wrap();
    test_load_priority();
`ifdef ACLK_LOAD_CHECK_EN
    test_load_check();
`else
    test_unchecked_load();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aclk_time_counter.md
Name: aclk_time_counter

Overview:
- Real-time BCD counter for the alarm clock. Holds current time as four BCD digits, HH:MM, in 24-hour format.
- Advances once per minute, derived from a 1 Hz enable pulse.
- Accepts a parallel load of a new time from the key register.
- Drives the current_time_* digit inputs of the LCD display stage directly downstream.

Parameters:
- SEC_PER_MIN, 60: number of one_second pulses per minute increment. Legal range 2..255. The bench uses a small value.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- one_second  input  1  single-cycle 1 Hz enable pulse, synchronous to clock
- load_new_c  input  1  single-cycle strobe: load new_current_time_* into the counter
- new_current_time_ms_hr  input  4  BCD tens-of-hours to load
- new_current_time_ls_hr  input  4  BCD units-of-hours to load
- new_current_time_ms_min  input  4  BCD tens-of-minutes to load
- new_current_time_ls_min  input  4  BCD units-of-minutes to load
- current_time_ms_hr  output  4  registered BCD tens-of-hours
- current_time_ls_hr  output  4  registered BCD units-of-hours
- current_time_ms_min  output  4  registered BCD tens-of-minutes
- current_time_ls_min  output  4  registered BCD units-of-minutes
- minute_tick  output  1  one-cycle pulse, asserted in the cycle in which minutes advance
- day_wrap  output  1  one-cycle pulse, asserted when the time advances 23:59 -> 00:00
- load_err  output  1  one-cycle pulse on a rejected load (feature only; otherwise constant 0)

Behaviour:
- Clock and reset:
  - One clock domain, rising edge.
  - reset is asynchronous and active-high. It forces all digits to 0 (00:00), the internal seconds counter to 0, and minute_tick, day_wrap and load_err to 0.
- Seconds prescaler:
  - 8-bit sec_cnt increments on each cycle with one_second=1.
  - When sec_cnt == SEC_PER_MIN-1 and one_second=1: sec_cnt goes to 0 and a minute increment fires in the same edge.
  - Outputs are valid on the following cycle (latency 1).
- Minute increment (cascade, all in one edge):
  - ls_min: if >= 9, goes to 0 and carries; else +1.
  - On carry, ms_min: if >= 5, goes to 0 and carries to hours; else +1.
  - On hour carry: if ms_hr >= 2 and ls_hr >= 3, both go to 0 and day_wrap=1. Else if ls_hr >= 9, ls_hr goes to 0 and ms_hr +1. Else ls_hr +1.
  - minute_tick=1 on every minute increment.
- The >= comparisons make out-of-range values (possible via an unchecked load) self-correct at the next rollover. The counter never sticks.
- Load:
  - load_new_c=1 copies the four new_current_time_* digits into the registers at the next edge and clears sec_cnt to 0.
  - minute_tick and day_wrap are 0 in a load cycle.
- Simultaneous load_new_c and one_second: load wins. The tick is discarded and sec_cnt is 0 after the edge.
- Load while a minute rollover is due (sec_cnt == SEC_PER_MIN-1): load wins, no increment.
- Reset mid-count: asynchronous clear takes effect immediately. The first minute after release needs a full SEC_PER_MIN pulses.
- Pulses: minute_tick, day_wrap and load_err are registered, exactly one cycle wide, and never asserted in the same cycle as reset.

Optional Feature:
- Macro: ACLK_LOAD_CHECK_EN
- Defined: a load is accepted only if all of the following hold; otherwise it is rejected.
  - ls_min <= 9
  - ms_min <= 5
  - ls_hr <= 9
  - ms_hr <= 2
  - ms_hr == 2 implies ls_hr <= 3
- On rejection: time and sec_cnt are unchanged and load_err pulses for one cycle. A one_second pulse in the same cycle is still discarded.
- Not defined: every load is accepted and load_err is tied to 0.

Test Plan:
- Assert reset mid-count at 12:34 -> outputs 00:00 immediately (asynchronous), minute_tick=0, day_wrap=0.
- SEC_PER_MIN=4, load 00:09, then 4 one_second pulses -> after the 4th pulse outputs read 00:10 and minute_tick pulses for exactly 1 cycle. After 3 pulses outputs are still 00:09.
- Load 23:59, then SEC_PER_MIN pulses -> 00:00 with day_wrap=1 and minute_tick=1 in the same cycle. Load 09:59 and roll -> 10:00, day_wrap=0.
- Set sec_cnt to SEC_PER_MIN-1, then assert load_new_c=1 (load 07:30) together with one_second=1 -> outputs 07:30 with no increment. Exactly SEC_PER_MIN further pulses are needed to reach 07:31.
- With ACLK_LOAD_CHECK_EN: load 24:00 -> time unchanged, load_err=1 for 1 cycle. Load 19:60 -> rejected. Load 23:59 -> accepted, load_err=0.
- Without ACLK_LOAD_CHECK_EN: load 00:0F (ls_min=15), then one minute of pulses -> 00:10, load_err stays 0.
